// File: rtl/serial_adder_seq_pkg.sv
// rtl/serial_adder_seq_pkg.sv - shared state encoding and counter sizing for the serial adder
package serial_adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step counter must hold 0..WIDTH/2-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int steps;
        steps = width / 2;
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_seq_two_bit_adder.sv
// rtl/serial_adder_seq_two_bit_adder.sv - two-bit ripple-carry slice (twoBitAdder)
module twoBitAdder (
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    input  logic cin,
    output logic s0,
    output logic s1,
    output logic cout
);

    logic c1;

    assign s0   = a0 ^ b0 ^ cin;
    assign c1   = (a0 & b0) | (cin & (a0 ^ b0));
    assign s1   = a1 ^ b1 ^ c1;
    assign cout = (a1 & b1) | (c1 & (a1 ^ b1));

endmodule

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - adds two WIDTH-bit operands two bits per clock through one slice
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = WIDTH / 2;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("serial_adder_seq: WIDTH must be even and at least 2");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               s0, s1, slice_cout;
    logic [WIDTH-1:0]   psum_shifted;

    twoBitAdder u_slice (
        .a0   (a_q[0]),
        .a1   (a_q[1]),
        .b0   (b_q[0]),
        .b1   (b_q[1]),
        .cin  (carry_q),
        .s0   (s0),
        .s1   (s1),
        .cout (slice_cout)
    );

    // New slice bits enter at the top; after N steps the first pair sits at bit 0.
    assign psum_shifted = WIDTH'({s1, s0, psum_q} >> 2);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 2;
                b_d     = b_q >> 2;
                psum_d  = psum_shifted;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    sum_d   = psum_shifted;
                    cout_d  = slice_cout;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
